synth_param_ctrl: RTL and testbench
===================================

SYNTH_PARAM_CTRL -- requirements
Module: synth_param_ctrl

Interface
REQ-001 SHALL have parameter OCT_DEFAULT, default 3'd4, octave value loaded at reset.
REQ-002 SHALL have parameter VOL_DEFAULT, default 4'd8, volume value loaded at reset.
REQ-003 SHALL have parameter VOL_MAX, default 4'd15, upper volume saturation limit.
REQ-004 SHALL have port clk  input  1  system clock; sole clock, all state on posedge clk.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port btn_up  input  1  debounced up-button pulse; may stay high for many clk cycles.
REQ-007 SHALL have port btn_down  input  1  debounced down-button pulse; same form as btn_up.
REQ-008 SHALL have port btn_sel  input  1  debounced select-button pulse; same form as btn_up.
REQ-009 SHALL have port param_idx  output  2  parameter under edit: 0 octave, 1 waveform, 2 volume, 3 transpose.
REQ-010 SHALL have port octave  output  3  octave, range 0..7.
REQ-011 SHALL have port waveform  output  2  waveform code, range 0..3.
REQ-012 SHALL have port volume  output  4  volume, range 0..VOL_MAX.
REQ-013 SHALL have port transpose  output  4  two's-complement semitone offset, range -6..+6.
REQ-014 SHALL have port param_changed  output  1  one-clk strobe when any parameter value changes.

Function
REQ-015 SHALL register each button input and rising-edge detect it on clk (current high, previous low); one input pulse of any length SHALL produce exactly one event.
REQ-016 SHALL implement FSM states EDIT_OCT, EDIT_WAVE, EDIT_VOL, EDIT_TRANS; param_idx SHALL equal the state encoding 0..3.
REQ-017 SHALL advance state on a sel event: OCT->WAVE->VOL->TRANS->OCT; sel events SHALL not alter any parameter value.
REQ-018 SHALL apply an up event by incrementing, and a down event by decrementing, only the parameter of the current state.
REQ-019 SHALL saturate octave at 0 and 7.
REQ-020 SHALL wrap waveform modulo 4 (3 up -> 0, 0 down -> 3).
REQ-021 SHALL saturate volume at 0 and VOL_MAX.
REQ-022 SHALL saturate transpose at -6 (4'b1010) and +6 (4'b0110), using signed comparison.
REQ-023 SHALL register all outputs; value and state updates SHALL appear 2 clk cycles after the input rising edge: 1 cycle edge detect, 1 cycle update.
REQ-024 SHALL pulse param_changed high for exactly one clk, in the same cycle the new value first appears, only if the value actually differs from its previous value; up or down at a limit SHALL produce no strobe.
REQ-025 SHALL ignore both up and down when their events coincide in one cycle.
REQ-026 SHALL give a sel event priority over up/down events in the same cycle: the state advances, and the up/down events are discarded and not applied to either parameter.
REQ-027 SHALL hold state and all parameter values when no event occurs.

Reset
REQ-028 SHALL, while rst is high at posedge clk, set state EDIT_OCT, param_idx 0, octave OCT_DEFAULT, waveform 0, volume VOL_DEFAULT, transpose 0, param_changed 0.
REQ-029 SHALL clear the edge-detect history to 0 on reset; a button held high through reset release SHALL produce one event after release.
REQ-030 SHALL let reset override any in-progress event; no update from that event SHALL occur after reset.

Verification
REQ-031 SHALL test: reset, then btn_up held high 1000 cycles -> octave 4->5 exactly once, one param_changed strobe, 2 clk after the edge.
REQ-032 SHALL test: 4 up pulses in EDIT_OCT from 4 -> octave 5,6,7,7; strobes on the first three pulses only.
REQ-033 SHALL test: sel pulse, then down pulse -> param_idx 1, waveform 0->3 with strobe; 4 sel pulses total -> param_idx back to 0.
REQ-034 SHALL test: in EDIT_TRANS, 8 down pulses -> transpose stops at 4'b1010 (-6); 13 up pulses then -> stops at 4'b0110 (+6).
REQ-035 SHALL test: btn_up and btn_down rising in the same cycle -> no value change, no strobe; btn_sel and btn_up rising together in EDIT_OCT -> param_idx 1, octave and waveform unchanged.
REQ-036 SHALL test: rst asserted 1 cycle after an up edge in EDIT_VOL with volume 9 -> volume 8 (VOL_DEFAULT), param_idx 0, no strobe.

Source files
------------

// File: rtl/synth_param_ctrl.sv
// Four-parameter synth front-panel editor: sel cycles the edited parameter,
// up/down adjust it with per-parameter saturation or wrap.
module synth_param_ctrl #(
  parameter logic [2:0] OCT_DEFAULT = 3'd4,
  parameter logic [3:0] VOL_DEFAULT = 4'd8,
  parameter logic [3:0] VOL_MAX     = 4'd15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_sel,
  output logic [1:0] param_idx,
  output logic [2:0] octave,
  output logic [1:0] waveform,
  output logic [3:0] volume,
  output logic [3:0] transpose,
  output logic       param_changed
);

  localparam int unsigned IDX_W   = 2;
  localparam int unsigned OCT_W   = 3;
  localparam int unsigned WAVE_W  = 2;
  localparam int unsigned VOL_W   = 4;
  localparam int unsigned TRANS_W = 4;
  localparam int unsigned BTN_W   = 3;

  localparam logic [OCT_W-1:0]          OCT_MAX   = OCT_W'(7);
  localparam logic signed [TRANS_W-1:0] TRANS_MAX = 4'sd6;
  localparam logic signed [TRANS_W-1:0] TRANS_MIN = -4'sd6;

  typedef enum logic [IDX_W-1:0] {
    EDIT_OCT   = 2'd0,
    EDIT_WAVE  = 2'd1,
    EDIT_VOL   = 2'd2,
    EDIT_TRANS = 2'd3
  } state_t;

  state_t               state, state_nxt;
  logic [BTN_W-1:0]     btn_q, btn_prev;
  logic [BTN_W-1:0]     evt_c;
  logic                 up_c, down_c, sel_c;
  logic [OCT_W-1:0]     oct_nxt;
  logic [WAVE_W-1:0]    wave_nxt;
  logic [VOL_W-1:0]     vol_nxt;
  logic [TRANS_W-1:0]   trans_nxt;
  logic                 changed_c;

  // Button bit order is {sel, down, up}; an event is "now high, was low".
  assign evt_c  = btn_q & ~btn_prev;
  assign sel_c  = evt_c[2];
  assign up_c   = evt_c[0] & ~evt_c[1];
  assign down_c = evt_c[1] & ~evt_c[0];

  // Next state and parameter values; sel wins over any same-cycle up/down.
  always_comb begin
    state_nxt = state;
    oct_nxt   = octave;
    wave_nxt  = waveform;
    vol_nxt   = volume;
    trans_nxt = transpose;
    if (sel_c) begin
      state_nxt = state_t'(IDX_W'(state) + IDX_W'(1));
    end else if (up_c || down_c) begin
      case (state)
        EDIT_OCT: begin
          if (up_c && octave != OCT_MAX)            oct_nxt = octave + OCT_W'(1);
          if (down_c && octave != '0)               oct_nxt = octave - OCT_W'(1);
        end
        EDIT_WAVE: begin
          if (up_c)                                 wave_nxt = waveform + WAVE_W'(1);
          if (down_c)                               wave_nxt = waveform - WAVE_W'(1);
        end
        EDIT_VOL: begin
          if (up_c && volume < VOL_MAX)             vol_nxt = volume + VOL_W'(1);
          if (down_c && volume != '0)               vol_nxt = volume - VOL_W'(1);
        end
        EDIT_TRANS: begin
          if (up_c && $signed(transpose) < TRANS_MAX)   trans_nxt = transpose + TRANS_W'(1);
          if (down_c && $signed(transpose) > TRANS_MIN) trans_nxt = transpose - TRANS_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign changed_c = {oct_nxt, wave_nxt, vol_nxt, trans_nxt} !=
                     {octave, waveform, volume, transpose};

  // All state and outputs; reset also clears the edge-detect history.
  always_ff @(posedge clk) begin
    if (rst) begin
      btn_q         <= '0;
      btn_prev      <= '0;
      state         <= EDIT_OCT;
      octave        <= OCT_DEFAULT;
      waveform      <= '0;
      volume        <= VOL_DEFAULT;
      transpose     <= '0;
      param_changed <= 1'b0;
    end else begin
      btn_q         <= {btn_sel, btn_down, btn_up};
      btn_prev      <= btn_q;
      state         <= state_nxt;
      octave        <= oct_nxt;
      waveform      <= wave_nxt;
      volume        <= vol_nxt;
      transpose     <= trans_nxt;
      param_changed <= changed_c;
    end
  end

  assign param_idx = IDX_W'(state);

endmodule

// File: tb/tb_synth_param_ctrl.sv
// Bench for synth_param_ctrl: directed scenarios plus random button traffic,
// checked against an integer-arithmetic model of the parameter rules.
module tb_synth_param_ctrl;

  localparam int OCT_DEF = 4;
  localparam int VOL_DEF = 8;
  localparam int VOL_MX  = 15;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_up = 1'b0, btn_down = 1'b0, btn_sel = 1'b0;
  logic [1:0] param_idx;
  logic [2:0] octave;
  logic [1:0] waveform;
  logic [3:0] volume;
  logic [3:0] transpose;
  logic       param_changed;

  int vectors = 0;
  int miscompares = 0;

  // Model state in plain integers
  int m_idx, m_oct, m_wave, m_vol, m_trans;

  synth_param_ctrl dut (
    .clk(clk), .rst(rst), .btn_up(btn_up), .btn_down(btn_down), .btn_sel(btn_sel),
    .param_idx(param_idx), .octave(octave), .waveform(waveform), .volume(volume),
    .transpose(transpose), .param_changed(param_changed)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] pack(input int idx, oct, wave, vol, trans, input bit chg);
    logic [3:0] t;
    t = 4'(trans);
    return {2'(idx), 3'(oct), 2'(wave), 4'(vol), t, chg};
  endfunction

  function automatic logic [15:0] observe();
    return {param_idx, octave, waveform, volume, transpose, param_changed};
  endfunction

  function automatic int clamp(input int v, lo, hi);
    return (v < lo) ? lo : (v > hi) ? hi : v;
  endfunction

  function automatic void model_reset();
    m_idx = 0; m_oct = OCT_DEF; m_wave = 0; m_vol = VOL_DEF; m_trans = 0;
  endfunction

  // Expected outputs one cycle after the edge (e1), two cycles after (e2),
  // once settled (el) and the expected number of strobes (ec).
  function automatic void model_event(input logic [2:0] mask, output logic [15:0] e1, e2, el,
                                      output int ec);
    int d, old;
    bit chg;
    e1  = pack(m_idx, m_oct, m_wave, m_vol, m_trans, 1'b0);
    chg = 1'b0;
    if (mask[2]) begin
      m_idx = (m_idx + 1) % 4;
    end else if (mask[0] != mask[1]) begin
      d = mask[0] ? 1 : -1;
      case (m_idx)
        0: begin old = m_oct;   m_oct   = clamp(m_oct + d, 0, 7);       chg = (old != m_oct);   end
        1: begin old = m_wave;  m_wave  = (m_wave + d + 4) % 4;         chg = (old != m_wave);  end
        2: begin old = m_vol;   m_vol   = clamp(m_vol + d, 0, VOL_MX);  chg = (old != m_vol);   end
        default: begin old = m_trans; m_trans = clamp(m_trans + d, -6, 6); chg = (old != m_trans); end
      endcase
    end
    e2 = pack(m_idx, m_oct, m_wave, m_vol, m_trans, chg);
    el = pack(m_idx, m_oct, m_wave, m_vol, m_trans, 1'b0);
    ec = chg ? 1 : 0;
  endfunction

  // Drive a button combination for `hold` cycles and record the outputs.
  task automatic press(input logic [2:0] mask, input int hold, input bit preset,
                       output logic [15:0] o1, o2, ol, output int scnt);
    logic [15:0] obs;
    scnt = 0;
    o1 = '0; o2 = '0;
    if (!preset) begin
      @(posedge clk); #1;
      {btn_sel, btn_down, btn_up} = mask;
    end
    for (int k = 1; k <= hold + 3; k++) begin
      @(posedge clk); #1;
      obs = observe();
      if (k == 1) o1 = obs;
      if (k == 2) o2 = obs;
      if (param_changed) scnt++;
      if (k == hold) {btn_sel, btn_down, btn_up} = 3'b000;
    end
    ol = observe();
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    {btn_sel, btn_down, btn_up} = 3'b000;
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic goto_idx(input int target);
    logic [15:0] e1, e2, el, o1, o2, ol;
    int ec, sc;
    while (m_idx != target) begin
      model_event(3'b100, e1, e2, el, ec);
      press(3'b100, 1, 1'b0, o1, o2, ol, sc);
    end
  endtask

  task automatic test_reset();
    logic [15:0] exp_v;
    do_reset();
    exp_v = pack(0, OCT_DEF, 0, VOL_DEF, 0, 1'b0);
    vectors++;
    if (observe() !== exp_v) begin
      miscompares++;
      $display("FAIL reset_state got=%h exp=%h", observe(), exp_v);
    end
  endtask

  task automatic test_long_hold();
    logic [15:0] e1, e2, el, o1, o2, ol;
    int ec, sc;
    do_reset();
    model_event(3'b001, e1, e2, el, ec);
    press(3'b001, 1000, 1'b0, o1, o2, ol, sc);
    vectors++;
    if ({o1, o2} !== {e1, e2}) begin
      miscompares++;
      $display("FAIL long_hold_timing got=%h/%h exp=%h/%h", o1, o2, e1, e2);
    end
    vectors++;
    if ({ol, 32'(sc)} !== {el, 32'(ec)} || octave !== 3'd5) begin
      miscompares++;
      $display("FAIL long_hold_final got=%h strobes=%0d exp=%h strobes=%0d", ol, sc, el, ec);
    end
  endtask

  task automatic test_oct_saturate();
    logic [15:0] e1, e2, el, o1, o2, ol;
    int ec, sc;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      model_event(3'b001, e1, e2, el, ec);
      press(3'b001, 1 + i, 1'b0, o1, o2, ol, sc);
      vectors++;
      if ({o1, o2, ol, 32'(sc)} !== {e1, e2, el, 32'(ec)}) begin
        miscompares++;
        $display("FAIL oct_up_%0d got=%h/%h/%h s=%0d exp=%h/%h/%h s=%0d", i, o1, o2, ol, sc, e1, e2, el, ec);
      end
    end
    vectors++;
    if (octave !== 3'd7) begin
      miscompares++;
      $display("FAIL oct_limit got=%0d exp=7", octave);
    end
  endtask

  task automatic test_wave_and_sel();
    logic [15:0] e1, e2, el, o1, o2, ol;
    int ec, sc;
    logic [2:0] seq [5] = '{3'b100, 3'b010, 3'b100, 3'b100, 3'b100};
    for (int i = 0; i < 5; i++) begin
      model_event(seq[i], e1, e2, el, ec);
      press(seq[i], 2, 1'b0, o1, o2, ol, sc);
      vectors++;
      if ({o1, o2, ol, 32'(sc)} !== {e1, e2, el, 32'(ec)}) begin
        miscompares++;
        $display("FAIL wave_sel_%0d got=%h/%h/%h s=%0d exp=%h/%h/%h s=%0d", i, o1, o2, ol, sc, e1, e2, el, ec);
      end
    end
    vectors++;
    if (param_idx !== 2'd0 || waveform !== 2'd3) begin
      miscompares++;
      $display("FAIL wave_final got idx=%0d wave=%0d exp idx=0 wave=3", param_idx, waveform);
    end
  endtask

  task automatic test_trans_saturate();
    logic [15:0] e1, e2, el, o1, o2, ol;
    int ec, sc;
    goto_idx(3);
    for (int i = 0; i < 21; i++) begin
      logic [2:0] m;
      m = (i < 8) ? 3'b010 : 3'b001;
      model_event(m, e1, e2, el, ec);
      press(m, 1, 1'b0, o1, o2, ol, sc);
      vectors++;
      if ({o1, o2, ol, 32'(sc)} !== {e1, e2, el, 32'(ec)}) begin
        miscompares++;
        $display("FAIL trans_%0d got=%h/%h/%h s=%0d exp=%h/%h/%h s=%0d", i, o1, o2, ol, sc, e1, e2, el, ec);
      end
      if (i == 7) begin
        vectors++;
        if (transpose !== 4'b1010) begin
          miscompares++;
          $display("FAIL trans_min got=%b exp=1010", transpose);
        end
      end
    end
    vectors++;
    if (transpose !== 4'b0110) begin
      miscompares++;
      $display("FAIL trans_max got=%b exp=0110", transpose);
    end
  endtask

  task automatic test_coincide();
    logic [15:0] e1, e2, el, o1, o2, ol;
    int ec, sc;
    logic [2:0] masks [2] = '{3'b011, 3'b101};
    goto_idx(0);
    for (int i = 0; i < 2; i++) begin
      model_event(masks[i], e1, e2, el, ec);
      press(masks[i], 2, 1'b0, o1, o2, ol, sc);
      vectors++;
      if ({o1, o2, ol, 32'(sc)} !== {e1, e2, el, 32'(ec)}) begin
        miscompares++;
        $display("FAIL coincide_%0d got=%h/%h/%h s=%0d exp=%h/%h/%h s=%0d", i, o1, o2, ol, sc, e1, e2, el, ec);
      end
    end
  endtask

  task automatic test_held_through_reset();
    logic [15:0] e1, e2, el, o1, o2, ol;
    int ec, sc;
    @(posedge clk); #1;
    rst = 1'b1;
    btn_up = 1'b1;
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    model_event(3'b001, e1, e2, el, ec);
    press(3'b001, 3, 1'b1, o1, o2, ol, sc);
    vectors++;
    if ({o1, o2, ol, 32'(sc)} !== {e1, e2, el, 32'(ec)}) begin
      miscompares++;
      $display("FAIL held_reset got=%h/%h/%h s=%0d exp=%h/%h/%h s=%0d", o1, o2, ol, sc, e1, e2, el, ec);
    end
  endtask

  task automatic test_reset_abort();
    logic [15:0] e1, e2, el, o1, o2, ol, exp_v;
    int ec, sc;
    do_reset();
    goto_idx(2);
    model_event(3'b001, e1, e2, el, ec);
    press(3'b001, 1, 1'b0, o1, o2, ol, sc);
    vectors++;
    if (volume !== 4'd9) begin
      miscompares++;
      $display("FAIL abort_setup got vol=%0d exp=9", volume);
    end
    @(posedge clk); #1;
    btn_up = 1'b1;
    @(posedge clk); #1;
    btn_up = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    exp_v = pack(0, OCT_DEF, 0, VOL_DEF, 0, 1'b0);
    sc = 0;
    for (int k = 0; k < 4; k++) begin
      if (param_changed) sc++;
      if (k < 3) begin
        @(posedge clk); #1;
      end
    end
    vectors++;
    if ({observe(), 32'(sc)} !== {exp_v, 32'd0}) begin
      miscompares++;
      $display("FAIL reset_abort got=%h s=%0d exp=%h s=0", observe(), sc, exp_v);
    end
  endtask

  task automatic test_random();
    logic [15:0] e1, e2, el, o1, o2, ol;
    int ec, sc, hold;
    logic [2:0] m;
    for (int i = 0; i < 120; i++) begin
      m    = 3'($urandom_range(1, 7));
      hold = $urandom_range(1, 4);
      model_event(m, e1, e2, el, ec);
      press(m, hold, 1'b0, o1, o2, ol, sc);
      vectors++;
      if ({o1, o2, ol, 32'(sc)} !== {e1, e2, el, 32'(ec)}) begin
        miscompares++;
        $display("FAIL random_%0d mask=%b got=%h/%h/%h s=%0d exp=%h/%h/%h s=%0d",
                 i, m, o1, o2, ol, sc, e1, e2, el, ec);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_long_hold();
    test_oct_saturate();
    test_wave_and_sel();
    test_trans_saturate();
    test_coincide();
    test_held_through_reset();
    test_reset_abort();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
